// File: rtl/day1_line_digits.sv
// Streaming calibration-line decoder: finds the first and last digit of each
// ASCII line (optionally spelled-out words) and emits 10*first + last per line.
module day1_line_digits #(
    parameter bit SPELLED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tvalid_rx,
    output logic        tready_rx,
    input  logic [7:0]  tdata_rx,
    input  logic        tlast_rx,
    output logic        tvalid_tx,
    input  logic        tready_tx,
    output logic [7:0]  tdata_tx,
    output logic        tlast_tx,
    output logic [15:0] line_count
);

    logic [31:0] hist_q, hist_d;
    logic [3:0]  first_q, first_d;
    logic [3:0]  last_q, last_d;
    logic        seen_q, seen_d;
    logic        tvalid_q, tvalid_d;
    logic [7:0]  tdata_q, tdata_d;
    logic [15:0] count_q, count_d;

    logic [39:0] win;
    logic        dig_found;
    logic [3:0]  dig_val;
    logic        accept;
    logic [3:0]  first_eff, last_eff;
    logic [6:0]  line_val;

    assign tready_rx  = !tvalid_q || tready_tx;
    assign accept     = tvalid_rx && tready_rx;
    assign tvalid_tx  = tvalid_q;
    assign tdata_tx   = tdata_q;
    assign tlast_tx   = 1'b0;
    assign line_count = count_q;

    // Oldest byte in the top slice; the current byte closes the window.
    assign win = {hist_q, tdata_rx};

    always_comb begin
        dig_found = 1'b0;
        dig_val   = 4'd0;
        if (tdata_rx >= 8'h30 && tdata_rx <= 8'h39) begin
            dig_found = 1'b1;
            dig_val   = tdata_rx[3:0];
        end else if (SPELLED) begin
            if (win[23:0] == "one") begin
                dig_found = 1'b1; dig_val = 4'd1;
            end else if (win[23:0] == "two") begin
                dig_found = 1'b1; dig_val = 4'd2;
            end else if (win[39:0] == "three") begin
                dig_found = 1'b1; dig_val = 4'd3;
            end else if (win[31:0] == "four") begin
                dig_found = 1'b1; dig_val = 4'd4;
            end else if (win[31:0] == "five") begin
                dig_found = 1'b1; dig_val = 4'd5;
            end else if (win[23:0] == "six") begin
                dig_found = 1'b1; dig_val = 4'd6;
            end else if (win[39:0] == "seven") begin
                dig_found = 1'b1; dig_val = 4'd7;
            end else if (win[39:0] == "eight") begin
                dig_found = 1'b1; dig_val = 4'd8;
            end else if (win[31:0] == "nine") begin
                dig_found = 1'b1; dig_val = 4'd9;
            end
        end
    end

    // Line result must include a digit found on the closing beat itself.
    always_comb begin
        first_eff = (dig_found && !seen_q) ? dig_val : first_q;
        last_eff  = dig_found ? dig_val : last_q;
        if (seen_q || dig_found) begin
            line_val = {first_eff, 3'b000} + {2'b00, first_eff, 1'b0} + {3'b000, last_eff};
        end else begin
            line_val = 7'd0;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        first_d = first_q;
        last_d  = last_q;
        seen_d  = seen_q;
        if (accept) begin
            if (tlast_rx) begin
                hist_d  = 32'd0;
                first_d = 4'd0;
                last_d  = 4'd0;
                seen_d  = 1'b0;
            end else begin
                hist_d = {hist_q[23:0], tdata_rx};
                if (dig_found) begin
                    first_d = first_eff;
                    last_d  = dig_val;
                    seen_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        count_d  = count_q;
        if (tvalid_q && tready_tx) begin
            tvalid_d = 1'b0;
            count_d  = count_q + 16'd1;
        end
        if (accept && tlast_rx) begin
            tvalid_d = 1'b1;
            tdata_d  = {1'b0, line_val};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q   <= 32'd0;
            first_q  <= 4'd0;
            last_q   <= 4'd0;
            seen_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'd0;
            count_q  <= 16'd0;
        end else begin
            hist_q   <= hist_d;
            first_q  <= first_d;
            last_q   <= last_d;
            seen_q   <= seen_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_day1_line_digits.sv
// Directed bench for day1_line_digits: one instance with spelled words enabled,
// one digits-only instance sharing the same input stream.
module tb_day1_line_digits;

    logic        clk;
    logic        rst;
    logic        tvalid_rx;
    logic [7:0]  tdata_rx;
    logic        tlast_rx;
    logic        tready_tx;
    logic        tready_rx, tready_rx0;
    logic        tvalid_tx, tvalid_tx0;
    logic [7:0]  tdata_tx, tdata_tx0;
    logic        tlast_tx, tlast_tx0;
    logic [15:0] line_count, line_count0;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_exp  = 0;

    day1_line_digits #(.SPELLED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .tvalid_rx(tvalid_rx), .tready_rx(tready_rx), .tdata_rx(tdata_rx), .tlast_rx(tlast_rx),
        .tvalid_tx(tvalid_tx), .tready_tx(tready_tx), .tdata_tx(tdata_tx), .tlast_tx(tlast_tx),
        .line_count(line_count)
    );

    day1_line_digits #(.SPELLED(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .tvalid_rx(tvalid_rx), .tready_rx(tready_rx0), .tdata_rx(tdata_rx), .tlast_rx(tlast_rx),
        .tvalid_tx(tvalid_tx0), .tready_tx(tready_tx), .tdata_tx(tdata_tx0), .tlast_tx(tlast_tx0),
        .line_count(line_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one beat and returns 1 time unit after the edge that accepted it.
    task automatic send_byte(input byte c, input bit last);
        int n;
        tvalid_rx = 1'b1;
        tdata_rx  = c;
        tlast_rx  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tready_rx && n < 50);
        n_checks++;
        if (!tready_rx) begin
            n_fail++;
            $display("FAIL send_timeout: tready_rx=%0b required 1 within 50 cycles", tready_rx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input string s, input int exp1, input int exp0);
        tready_tx = 1'b1;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], i == s.len() - 1);
        tvalid_rx = 1'b0;
        tlast_rx  = 1'b0;
        n_checks++;
        if (tvalid_tx !== 1'b1 || tdata_tx !== 8'(exp1)) begin
            n_fail++;
            $display("FAIL line_spelled \"%s\": valid=%0b data=%0d required valid=1 data=%0d", s, tvalid_tx, tdata_tx, exp1);
        end
        n_checks++;
        if (tvalid_tx0 !== 1'b1 || tdata_tx0 !== 8'(exp0)) begin
            n_fail++;
            $display("FAIL line_digits \"%s\": valid=%0b data=%0d required valid=1 data=%0d", s, tvalid_tx0, tdata_tx0, exp0);
        end
        n_checks++;
        if (tlast_tx !== 1'b0 || tlast_tx0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tlast_tx \"%s\": got %0b/%0b required 0", s, tlast_tx, tlast_tx0);
        end
        @(posedge clk);
        #1;
        cnt_exp++;
        n_checks++;
        if (tvalid_tx !== 1'b0 || line_count !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL drain \"%s\": valid=%0b count=%0d required valid=0 count=%0d", s, tvalid_tx, line_count, cnt_exp);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (tvalid_tx !== 1'b0 || tdata_tx !== 8'h00 || tlast_tx !== 1'b0 || line_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b data=%0d last=%0b count=%0d required 0/0/0/0", tvalid_tx, tdata_tx, tlast_tx, line_count);
        end
        n_checks++;
        if (tready_rx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: tready_rx=%0b required 1", tready_rx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (tready_rx !== 1'b1 || tvalid_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: ready=%0b valid=%0b required 1/0", tready_rx, tvalid_tx);
        end
    endtask

    task automatic test_lines();
        run_line("1abc2", 12, 12);
        run_line("two1nine", 29, 11);
        run_line("abc", 0, 0);
        run_line("treb7uchet", 77, 77);
        run_line("eightwothree", 83, 0);
        run_line("xtwone3four", 24, 33);
        run_line("on", 0, 0);
        run_line("e5", 55, 55);
    endtask

    task automatic test_backpressure();
        tready_tx = 1'b0;
        send_byte("1", 1'b0);
        send_byte("x", 1'b1);
        tvalid_rx = 1'b1;
        tdata_rx  = "3";
        tlast_rx  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (tvalid_tx !== 1'b1 || tdata_tx !== 8'd11 || tready_rx !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%0b data=%0d ready=%0b required 1/11/0", k, tvalid_tx, tdata_tx, tready_rx);
            end
        end
        @(posedge clk);
        #1;
        tready_tx = 1'b1;
        @(posedge clk);
        #1;
        cnt_exp++;
        tready_tx = 1'b0;
        n_checks++;
        if (tvalid_tx !== 1'b0 || line_count !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL bp_release: valid=%0b count=%0d required 0/%0d", tvalid_tx, line_count, cnt_exp);
        end
        send_byte("y", 1'b1);
        tvalid_rx = 1'b0;
        tlast_rx  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (tvalid_tx !== 1'b1 || tdata_tx !== 8'd33 || tdata_tx0 !== 8'd33) begin
            n_fail++;
            $display("FAIL bp_second: valid=%0b data=%0d/%0d required 1/33/33", tvalid_tx, tdata_tx, tdata_tx0);
        end
        tready_tx = 1'b1;
        @(posedge clk);
        #1;
        cnt_exp++;
        n_checks++;
        if (tvalid_tx !== 1'b0 || line_count !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%0b count=%0d required 0/%0d", tvalid_tx, line_count, cnt_exp);
        end
    endtask

    task automatic test_back_to_back();
        byte c;
        tready_tx = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c = 8'h37 + 8'(k);
            send_byte(c, 1'b1);
            n_checks++;
            if (tvalid_tx !== 1'b1 || tdata_tx !== 8'(77 + 11 * k)) begin
                n_fail++;
                $display("FAIL b2b%0d: valid=%0b data=%0d required 1/%0d", k, tvalid_tx, tdata_tx, 77 + 11 * k);
            end
        end
        tvalid_rx = 1'b0;
        tlast_rx  = 1'b0;
        @(posedge clk);
        #1;
        cnt_exp += 3;
        n_checks++;
        if (tvalid_tx !== 1'b0 || line_count !== 16'(cnt_exp)) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%0b count=%0d required 0/%0d", tvalid_tx, line_count, cnt_exp);
        end
    endtask

    task automatic test_reset_midline();
        tready_tx = 1'b1;
        send_byte("t", 1'b0);
        send_byte("w", 1'b0);
        tvalid_rx = 1'b0;
        rst = 1'b0;
        #1;
        cnt_exp = 0;
        n_checks++;
        if (tvalid_tx !== 1'b0 || line_count !== 16'd0 || tready_rx !== 1'b1) begin
            n_fail++;
            $display("FAIL midline_reset: valid=%0b count=%0d ready=%0b required 0/0/1", tvalid_tx, line_count, tready_rx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_line("o4", 44, 44);
    endtask

    initial begin
        rst       = 1'b0;
        tvalid_rx = 1'b0;
        tdata_rx  = 8'h00;
        tlast_rx  = 1'b0;
        tready_tx = 1'b1;
        test_reset();
        test_lines();
        test_backpressure();
        test_back_to_back();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/day1_line_digits.md
DAY1_LINE_DIGITS -- requirements
Module: day1_line_digits

Interface
REQ-001 Parameter: SPELLED, 1, when 1 the lowercase words "one".."nine" also count as digits 1..9; when 0 only ASCII '0'..'9' count.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 tvalid_rx  input  1  input beat valid.
REQ-005 tready_rx  output  1  block accepts input beat.
REQ-006 tdata_rx  input  8  ASCII character of current line.
REQ-007 tlast_rx  input  1  beat is the final character of its line.
REQ-008 tvalid_tx  output  1  line value available.
REQ-009 tready_tx  input  1  downstream accepts line value.
REQ-010 tdata_tx  output  8  line value, 10*first + last, range 0..99.
REQ-011 tlast_tx  output  1  constant 0; port kept for AXIS compatibility with the downstream summer.
REQ-012 line_count  output  16  number of line values accepted downstream, wraps modulo 2^16.

Function
REQ-013 An input beat SHALL be accepted when tvalid_rx and tready_rx are both 1 on a rising edge.
REQ-014 tready_rx SHALL be combinational: !tvalid_tx || tready_tx.
REQ-015 Digit detection: byte 0x30..0x39 SHALL give value 0..9; with SPELLED=1, a word whose last letter is the current accepted byte SHALL give its value, matched against the current byte plus up to 4 previous bytes of the same line.
REQ-016 Words SHALL overlap: "twone" yields 2 then 1; "eightwo" yields 8 then 2.
REQ-017 The first digit of a line SHALL set first and last; each later digit SHALL update last only.
REQ-018 The tlast_rx beat SHALL be processed as a line character before the line closes.
REQ-019 On an accepted tlast beat, tdata_tx SHALL load 10*first + last, including any digit found on that beat, and tvalid_tx SHALL be 1 from the next cycle. Latency is 1 cycle.
REQ-020 A line with no digit SHALL produce 0.
REQ-021 On an accepted tlast beat, first/last/seen and the character history SHALL clear, so no word spans two lines.
REQ-022 tvalid_tx and tdata_tx SHALL hold stable until tready_tx is sampled 1.
REQ-023 Output accepted and new tlast beat accepted in the same cycle: the new value SHALL load and tvalid_tx SHALL stay 1 with no bubble.
REQ-024 Output accepted with no new tlast beat: tvalid_tx SHALL drop to 0 the next cycle.
REQ-025 line_count SHALL increment by 1 on each tvalid_tx && tready_tx cycle; 0xFFFF wraps to 0x0000.
REQ-026 Arithmetic: 10*first + last SHALL be computed with at least 7-bit precision and zero-extended to 8 bits.

Reset
REQ-027 While rst=0: tvalid_tx=0, tdata_tx=0x00, tlast_tx=0, line_count=0, first/last/seen cleared, history filled with 0x00.
REQ-028 Reset asserted mid-line SHALL discard the partial line, and no value for it SHALL be emitted.
REQ-029 tready_rx SHALL be 1 during and after reset until an output is pending.

Verification
REQ-030 "1abc2", tlast on '2', tready_tx=1 -> tdata_tx=12 one cycle after the tlast beat, line_count=1.
REQ-031 "two1nine": SPELLED=1 -> 29; SPELLED=0 -> 11. "abc" -> 0. "treb7uchet" -> 77.
REQ-032 "eightwothree" -> 83; "xtwone3four" -> 24; "on" then tlast, then "e5" -> 0 then 55.
REQ-033 Backpressure: tready_tx=0, send "1x" then "3y". After the first tlast, tvalid_tx=1 with value 11 and tready_rx=0 until tready_tx=1. Then 33 follows, order is kept, and no beat is lost.
REQ-034 Back-to-back single-char lines "7","8","9" with tready_tx=1 -> 77, 88, 99 on consecutive cycles with tvalid_tx held 1.
REQ-035 rst=0 pulsed after "tw" mid-line, then "o4" with tlast -> only 44 emitted, line_count=1.
